// File: rtl/main_pkg.sv
// main_pkg: shared definitions for the LNS MAC datapath and its operand feeder.
//   IN_BITS         - LNS operand width minus one (operands are IN_BITS+1 bits, signed)
//   feeder_state_t  - operand feeder FSM states; the CLR state exists only when
//                     LNS_FEEDER_AUTO_CLR_EN is defined
//   lns_pair_t      - one staged operand pair {x, y, x_sign, y_sign}
package main_pkg;

  localparam int unsigned IN_BITS = 15;

`ifdef LNS_FEEDER_AUTO_CLR_EN
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CLR    = 2'd1,
    ST_STREAM = 2'd2,
    ST_DONE   = 2'd3
  } feeder_state_t;
`else
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd2,
    ST_DONE   = 2'd3
  } feeder_state_t;
`endif

  typedef struct packed {
    logic signed [IN_BITS:0] x;
    logic signed [IN_BITS:0] y;
    logic                    x_sign;
    logic                    y_sign;
  } lns_pair_t;

endpackage

// File: rtl/lns_pair_fifo.sv
// lns_pair_fifo: show-ahead FIFO of lns_pair_t entries.
//   clk, rstn   - clock, asynchronous active-low reset (empties the FIFO, zeroes storage)
//   push_i      - write request; ignored while full (no bypass through a same-cycle pop)
//   wr_data_i   - pair to write
//   pop_i       - read request; ignored while empty
//   rd_data_o   - head entry, valid whenever empty_o is low
//   full_o      - all DEPTH entries occupied
//   empty_o     - no entries
//   count_o     - current occupancy, 0..DEPTH
// DEPTH must be a power of two (pointers wrap by natural overflow) and at least 2.
module lns_pair_fifo
  import main_pkg::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       push_i,
  input  lns_pair_t                  wr_data_i,
  input  logic                       pop_i,
  output lns_pair_t                  rd_data_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  lns_pair_t       mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q;
  logic [AW-1:0]   rd_ptr_q;
  logic [AW:0]     count_q;
  logic [AW:0]     count_d;
  logic            push;
  logic            pop;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign push    = push_i && !full_o;
  assign pop     = pop_i && !empty_o;

  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // Storage is reset so the head (and hence the MAC operand outputs) reads as
  // zero after reset, including a reset that lands mid-vector.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= wr_data_i;
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      count_q <= count_d;
    end
  end

  assign rd_data_o = mem_q[rd_ptr_q];
  assign count_o   = count_q;

endmodule

// File: rtl/lns_operand_feeder.sv
// lns_operand_feeder: stages LNS operand pairs in a FIFO and streams exactly
// vec_len pairs into the LNS MAC's data_in_valid/data_in_enable handshake.
//   clk, rstn                          - clock, asynchronous active-low reset
//   wr_valid/wr_ready                  - host write handshake (wr_ready = !full)
//   wr_x, wr_y, wr_x_sign, wr_y_sign   - operand pair from the host
//   vec_len, start                     - vector length, sampled on a start pulse in IDLE
//   mac_data_in_valid/mac_data_in_enable - MAC handshake; a transfer pops the FIFO
//   mac_x, mac_y, mac_x_sign, mac_y_sign - FIFO head, driven straight to the MAC
//   mac_clr                            - one-cycle accumulator clear before each vector
//   busy, done                         - vector in progress / one-cycle completion pulse
//   fill_level                         - FIFO occupancy
// Build option: LNS_FEEDER_AUTO_CLR_EN adds the CLR state and drives mac_clr;
// without it mac_clr is tied low and the host clears the MAC itself.
module lns_operand_feeder
  import main_pkg::*;
#(
  parameter int unsigned DEPTH    = 8,
  parameter int unsigned LEN_BITS = 8
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       wr_valid,
  output logic                       wr_ready,
  input  logic signed [IN_BITS:0]    wr_x,
  input  logic signed [IN_BITS:0]    wr_y,
  input  logic                       wr_x_sign,
  input  logic                       wr_y_sign,
  input  logic [LEN_BITS-1:0]        vec_len,
  input  logic                       start,
  output logic                       mac_data_in_valid,
  input  logic                       mac_data_in_enable,
  output logic signed [IN_BITS:0]    mac_x,
  output logic signed [IN_BITS:0]    mac_y,
  output logic                       mac_x_sign,
  output logic                       mac_y_sign,
  output logic                       mac_clr,
  output logic                       busy,
  output logic                       done,
  output logic [$clog2(DEPTH):0]     fill_level
);

  feeder_state_t         state_q;
  logic [LEN_BITS-1:0]   cnt_q;
  logic                  busy_q;
  logic                  done_q;
  logic                  xfer;
  logic                  fifo_full;
  logic                  fifo_empty;
  lns_pair_t             wr_pair;
  lns_pair_t             head;

  assign wr_pair = '{x: wr_x, y: wr_y, x_sign: wr_x_sign, y_sign: wr_y_sign};

  lns_pair_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rstn      (rstn),
    .push_i    (wr_valid),
    .wr_data_i (wr_pair),
    .pop_i     (xfer),
    .rd_data_o (head),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty),
    .count_o   (fill_level)
  );

  assign wr_ready = !fifo_full;

  // Valid is decoded from registered state and occupancy so a pair written at
  // edge k can be offered in cycle k+1; it is low in every state but STREAM.
  assign mac_data_in_valid = (state_q == ST_STREAM) && !fifo_empty;
  assign xfer              = mac_data_in_valid && mac_data_in_enable;

  assign mac_x      = head.x;
  assign mac_y      = head.y;
  assign mac_x_sign = head.x_sign;
  assign mac_y_sign = head.y_sign;

`ifdef LNS_FEEDER_AUTO_CLR_EN
  logic clr_q;
  assign mac_clr = clr_q;
`else
  assign mac_clr = 1'b0;
`endif

  // done_q/clr_q are set on the transition into DONE/CLR so each is high for
  // exactly the one cycle spent in that state.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef LNS_FEEDER_AUTO_CLR_EN
      clr_q   <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
`ifdef LNS_FEEDER_AUTO_CLR_EN
      clr_q  <= 1'b0;
`endif
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            cnt_q  <= vec_len;
            busy_q <= 1'b1;
            if (vec_len == '0) begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
            end else begin
`ifdef LNS_FEEDER_AUTO_CLR_EN
              state_q <= ST_CLR;
              clr_q   <= 1'b1;
`else
              state_q <= ST_STREAM;
`endif
            end
          end
        end
`ifdef LNS_FEEDER_AUTO_CLR_EN
        ST_CLR: begin
          state_q <= ST_STREAM;
        end
`endif
        ST_STREAM: begin
          if (xfer) begin
            cnt_q <= cnt_q - LEN_BITS'(1);
            if (cnt_q == LEN_BITS'(1)) begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
            end
          end
        end
        ST_DONE: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_lns_operand_feeder.sv
module tb_lns_operand_feeder;
  import main_pkg::*;

  localparam int unsigned DEPTH    = 8;
  localparam int unsigned LEN_BITS = 8;

  logic                     clk = 1'b0;
  logic                     rstn;
  logic                     wr_valid;
  logic                     wr_ready;
  logic signed [IN_BITS:0]  wr_x;
  logic signed [IN_BITS:0]  wr_y;
  logic                     wr_x_sign;
  logic                     wr_y_sign;
  logic [LEN_BITS-1:0]      vec_len;
  logic                     start;
  logic                     mac_data_in_valid;
  logic                     mac_data_in_enable;
  logic signed [IN_BITS:0]  mac_x;
  logic signed [IN_BITS:0]  mac_y;
  logic                     mac_x_sign;
  logic                     mac_y_sign;
  logic                     mac_clr;
  logic                     busy;
  logic                     done;
  logic [$clog2(DEPTH):0]   fill_level;

  int checks = 0;
  int errors = 0;
  int xfers  = 0;
  int xfer_base;

  lns_operand_feeder #(
    .DEPTH    (DEPTH),
    .LEN_BITS (LEN_BITS)
  ) dut (
    .clk                (clk),
    .rstn               (rstn),
    .wr_valid           (wr_valid),
    .wr_ready           (wr_ready),
    .wr_x               (wr_x),
    .wr_y               (wr_y),
    .wr_x_sign          (wr_x_sign),
    .wr_y_sign          (wr_y_sign),
    .vec_len            (vec_len),
    .start              (start),
    .mac_data_in_valid  (mac_data_in_valid),
    .mac_data_in_enable (mac_data_in_enable),
    .mac_x              (mac_x),
    .mac_y              (mac_y),
    .mac_x_sign         (mac_x_sign),
    .mac_y_sign         (mac_y_sign),
    .mac_clr            (mac_clr),
    .busy               (busy),
    .done               (done),
    .fill_level         (fill_level)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mac_data_in_valid && mac_data_in_enable) xfers++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [15:0] px(input int i);
    return 16'h1000 + i[15:0];
  endfunction
  function automatic logic [15:0] py(input int i);
    return 16'h2000 + i[15:0];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic set_pair(input int i);
    wr_x      = px(i);
    wr_y      = py(i);
    wr_x_sign = i[0];
    wr_y_sign = i[1];
  endtask

  task automatic push(input int i);
    wr_valid = 1'b1;
    set_pair(i);
    step();
    wr_valid = 1'b0;
  endtask

  task automatic chk_head(input string tag, input int i);
    chk({tag, ".valid"}, {31'b0, mac_data_in_valid}, 32'd1);
    chk({tag, ".x"}, {16'b0, mac_x}, {16'b0, px(i)});
    chk({tag, ".y"}, {16'b0, mac_y}, {16'b0, py(i)});
    chk({tag, ".sx"}, {31'b0, mac_x_sign}, {31'b0, i[0]});
    chk({tag, ".sy"}, {31'b0, mac_y_sign}, {31'b0, i[1]});
  endtask

  // Issue start in IDLE and advance to the first STREAM cycle.
  task automatic kick(input int len);
    start   = 1'b1;
    vec_len = len[LEN_BITS-1:0];
    step();
    start   = 1'b0;
`ifdef LNS_FEEDER_AUTO_CLR_EN
    if (len != 0) begin
      chk("clr_pulse", {31'b0, mac_clr}, 32'd1);
      chk("clr_novalid", {31'b0, mac_data_in_valid}, 32'd0);
      step();
      chk("clr_once", {31'b0, mac_clr}, 32'd0);
    end
`endif
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, ".wr_ready"}, {31'b0, wr_ready}, 32'd1);
    chk({tag, ".valid"}, {31'b0, mac_data_in_valid}, 32'd0);
    chk({tag, ".clr"}, {31'b0, mac_clr}, 32'd0);
    chk({tag, ".busy"}, {31'b0, busy}, 32'd0);
    chk({tag, ".done"}, {31'b0, done}, 32'd0);
    chk({tag, ".fill"}, {28'b0, fill_level}, 32'd0);
    chk({tag, ".x"}, {16'b0, mac_x}, 32'd0);
    chk({tag, ".y"}, {16'b0, mac_y}, 32'd0);
    chk({tag, ".signs"}, {30'b0, mac_x_sign, mac_y_sign}, 32'd0);
  endtask

  initial begin
    rstn = 1'b0; wr_valid = 1'b0; wr_x = '0; wr_y = '0; wr_x_sign = 1'b0;
    wr_y_sign = 1'b0; vec_len = '0; start = 1'b0; mac_data_in_enable = 1'b0;
    step(); step();
    chk_reset_outputs("reset");
    rstn = 1'b1;
    step();

    // Basic vector of 4, enable held high: back-to-back transfers in order.
    for (int i = 0; i < 4; i++) push(i);
    chk("t1.fill4", {28'b0, fill_level}, 32'd4);
    chk("t1.idle_novalid", {31'b0, mac_data_in_valid}, 32'd0);
    mac_data_in_enable = 1'b1;
    xfer_base = xfers;
    kick(4);
    for (int i = 0; i < 4; i++) begin
      chk_head("t1.head", i);
      chk("t1.nodone", {31'b0, done}, 32'd0);
      step();
    end
    chk("t1.done", {31'b0, done}, 32'd1);
    chk("t1.busy_in_done", {31'b0, busy}, 32'd1);
    chk("t1.fill0", {28'b0, fill_level}, 32'd0);
    chk("t1.xfers", xfers - xfer_base, 32'd4);
    step();
    chk("t1.done_1cyc", {31'b0, done}, 32'd0);
    chk("t1.busy_low", {31'b0, busy}, 32'd0);

    // Fill to DEPTH, reject a 9th write, pop one while offering a write.
    for (int i = 10; i < 18; i++) push(i);
    chk("t2.full_ready", {31'b0, wr_ready}, 32'd0);
    chk("t2.fill8", {28'b0, fill_level}, 32'd8);
    push(99);
    chk("t2.fill_still8", {28'b0, fill_level}, 32'd8);
    kick(1);
    wr_valid = 1'b1;
    set_pair(99);
    chk_head("t2.pophead", 10);
    chk("t2.ready_low_on_pop", {31'b0, wr_ready}, 32'd0);
    step();
    wr_valid = 1'b0;
    chk("t2.ready_back", {31'b0, wr_ready}, 32'd1);
    chk("t2.fill7", {28'b0, fill_level}, 32'd7);
    chk("t2.done", {31'b0, done}, 32'd1);
    chk("t2.novalid_in_done", {31'b0, mac_data_in_valid}, 32'd0);
    step();
    kick(7);
    for (int i = 11; i < 18; i++) begin
      chk_head("t2.drain", i);
      step();
    end
    chk("t2.drain_done", {31'b0, done}, 32'd1);
    chk("t2.drain_fill0", {28'b0, fill_level}, 32'd0);
    step();

    // Underflow stall: vec_len 3 with one pair, rest supplied later.
    push(20);
    xfer_base = xfers;
    kick(3);
    chk_head("t3.first", 20);
    step();
    for (int k = 0; k < 4; k++) begin
      chk("t3.stall_valid", {31'b0, mac_data_in_valid}, 32'd0);
      chk("t3.stall_busy", {31'b0, busy}, 32'd1);
      chk("t3.stall_nodone", {31'b0, done}, 32'd0);
      step();
    end
    wr_valid = 1'b1;
    set_pair(21);
    step();
    set_pair(22);
    chk_head("t3.second", 21);
    step();
    wr_valid = 1'b0;
    chk_head("t3.third", 22);
    chk("t3.nodone", {31'b0, done}, 32'd0);
    step();
    chk("t3.done", {31'b0, done}, 32'd1);
    chk("t3.xfers", xfers - xfer_base, 32'd3);
    chk("t3.fill0", {28'b0, fill_level}, 32'd0);
    step();

    // Enable toggled 1,0,0,1: head held, count moves only on acceptance.
    push(30);
    push(31);
    xfer_base = xfers;
    kick(2);
    mac_data_in_enable = 1'b1;
    chk_head("t4.c0", 30);
    step();
    mac_data_in_enable = 1'b0;
    chk_head("t4.c1", 31);
    step();
    chk_head("t4.c2_hold", 31);
    chk("t4.c2_nodone", {31'b0, done}, 32'd0);
    step();
    mac_data_in_enable = 1'b1;
    chk_head("t4.c3", 31);
    chk("t4.c3_nodone", {31'b0, done}, 32'd0);
    step();
    chk("t4.done", {31'b0, done}, 32'd1);
    chk("t4.xfers", xfers - xfer_base, 32'd2);
    step();

    // Zero-length vector with a prefetched pair; second start while busy.
    push(40);
    xfer_base = xfers;
    kick(0);
    chk("t5.done", {31'b0, done}, 32'd1);
    chk("t5.noclr", {31'b0, mac_clr}, 32'd0);
    chk("t5.novalid", {31'b0, mac_data_in_valid}, 32'd0);
    chk("t5.busy", {31'b0, busy}, 32'd1);
    start   = 1'b1;
    vec_len = 8'd2;
    step();
    start   = 1'b0;
    chk("t5.idle_busy", {31'b0, busy}, 32'd0);
    chk("t5.idle_done", {31'b0, done}, 32'd0);
    step();
    chk("t5.ignored_busy", {31'b0, busy}, 32'd0);
    chk("t5.ignored_valid", {31'b0, mac_data_in_valid}, 32'd0);
    chk("t5.xfers", xfers - xfer_base, 32'd0);
    chk("t5.fill1", {28'b0, fill_level}, 32'd1);

    // Reset mid-STREAM with two pairs left.
    for (int i = 41; i < 44; i++) push(i);
    kick(4);
    chk_head("t6.p40", 40);
    step();
    chk_head("t6.p41", 41);
    step();
    chk_head("t6.p42", 42);
    rstn = 1'b0;
    #1;
    chk_reset_outputs("t6.async");
    step();
    chk_reset_outputs("t6.held");
    rstn = 1'b1;
    step();
    chk_reset_outputs("t6.after");
    step();
    chk("t6.no_done", {31'b0, done}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
